// File: rtl/bus_matrix_input_stage.sv
// Per-master input stage of the AHB bus matrix. It forwards the live address phase to the output
// stages and holds the transfer while no output stage grants it, stalling the master meanwhile.
module bus_matrix_input_stage #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_trans,
  input  logic                  HREADYM,
  input  logic                  HRESPM,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_trans,
  output logic                  trans_pend,
  output logic [ADDR_WIDTH-1:0] HADDRI,
  output logic [1:0]            HTRANSI,
  output logic                  HWRITEI,
  output logic [2:0]            HSIZEI,
  output logic [2:0]            HBURSTI,
  output logic [3:0]            HPROTI,
  output logic                  HMASTLOCKI
);

  typedef enum logic [1:0] {StIdle, StData, StPend} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            trans_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [2:0]            burst_q;
  logic [3:0]            prot_q;
  logic                  lock_q;
  logic                  trans_valid;
  logic                  pend;
  logic                  hold_en;

  assign trans_valid = HSELS & HTRANSS[1] & HREADYS;
  assign pend        = (state_q == StPend);
  // The held copy must stay frozen until an output stage takes it.
  assign hold_en     = HSELS & HREADYS & ~pend;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      trans_q <= 2'b00;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      burst_q <= 3'b000;
      prot_q  <= 4'b0000;
      lock_q  <= 1'b0;
    end else if (hold_en) begin
      addr_q  <= HADDRS;
      trans_q <= HTRANSS;
      write_q <= HWRITES;
      size_q  <= HSIZES;
      burst_q <= HBURSTS;
      prot_q  <= HPROTS;
      lock_q  <= HMASTLOCKS;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StData: begin
        if (HREADYS) begin
          if (trans_valid) begin
            state_d = active_trans ? StData : StPend;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StPend: begin
        if (active_trans & HREADYM) begin
          state_d = StData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    unique case (state_q)
      StData: begin
        HREADYOUTS = HREADYM;
        HRESPS     = HRESPM;
      end
      StPend: begin
        HREADYOUTS = 1'b0;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
      end
    endcase
  end

  // BUSY is forwarded as a request so the arbiter keeps the burst on this port.
  assign trans_pend = pend;
  assign sel_trans  = pend | (HSELS & (HTRANSS != 2'b00));
  assign HADDRI     = pend ? addr_q  : HADDRS;
  assign HTRANSI    = pend ? trans_q : (HSELS ? HTRANSS : 2'b00);
  assign HWRITEI    = pend ? write_q : HWRITES;
  assign HSIZEI     = pend ? size_q  : HSIZES;
  assign HBURSTI    = pend ? burst_q : HBURSTS;
  assign HPROTI     = pend ? prot_q  : HPROTS;
  assign HMASTLOCKI = pend ? lock_q  : HMASTLOCKS;

endmodule
